// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

    localparam int          INSTR_W   = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Synchronous prefetch FIFO: async-reset pointers, synchronous flush, combinational head read.
module fetch_unit_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot a full-queue push needs.
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, prefetch queue arbitration, redirect flush, IF/ID output gating.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          DATA_W   = INSTR_W,
    parameter int          IM_AW    = 12,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = fetch_unit_pkg::RESET_PC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_en,
    output logic [IM_AW-1:0]         im_addr,
    input  logic [DATA_W-1:0]        im_dout,
    input  logic                     redirect,
    input  logic [DATA_W-1:0]        redirect_pc,
    input  logic                     stall,
    output logic                     ifid_valid,
    output logic [DATA_W-1:0]        ifid_instr,
    output logic [DATA_W-1:0]        ifid_pc,
    output logic [DATA_W-1:0]        ifid_pc4,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     misalign
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0]   pc_q, pc_d;
    logic                misalign_q, misalign_d;
    logic                push, pop;
    logic                fifo_empty, fifo_full;
    logic [CW-1:0]       fifo_count;
    logic [2*DATA_W-1:0] head;
    logic [DATA_W-1:0]   head_pc, head_instr;

    assign ifid_valid = ~fifo_empty;
    assign pop        = ifid_valid & ~stall;
    assign push       = fetch_en & ~redirect & (~fifo_full | pop);

    always_comb begin
        pc_d       = pc_q;
        misalign_d = 1'b0;
        if (redirect) begin
            pc_d       = {redirect_pc[DATA_W-1:2], 2'b00};
            misalign_d = |redirect_pc[1:0];
        end else if (push) begin
            pc_d = pc_q + DATA_W'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= DATA_W'(RESET_PC);
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_unit_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (push),
        .pop   (pop),
        .wdata ({pc_q, im_dout}),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign head_pc    = head[2*DATA_W-1:DATA_W];
    assign head_instr = head[DATA_W-1:0];

    // Memory contents behind an empty queue are stale; decode must see a NOP at pc 0.
    assign ifid_instr = ifid_valid ? head_instr       : DATA_W'(NOP_INSTR);
    assign ifid_pc    = ifid_valid ? head_pc          : '0;
    assign ifid_pc4   = ifid_valid ? head_pc + DATA_W'(4) : '0;

    assign im_addr  = pc_q[IM_AW+1:2];
    assign q_count  = fifo_count;
    assign misalign = misalign_q;

endmodule
